// File: rtl/axi4_burst_sequencer.sv
// Single-outstanding AXI4 burst master: one INCR write or read burst per
// command, seed+beat data pattern, per-command status (worst response,
// read mismatch count, illegal-command and rlast-protocol flags).
module axi4_burst_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 64,
  parameter logic [3:0]  CACHE_VAL = 4'b0011
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [DATA_W-1:0]   cmd_seed,
  output logic                done,
  output logic                busy,
  output logic [1:0]          st_resp,
  output logic [8:0]          st_mismatch,
  output logic                st_illegal,
  output logic                st_proto,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHK  = 3'd1;
  localparam logic [2:0] AW   = 3'd2;
  localparam logic [2:0] W    = 3'd3;
  localparam logic [2:0] B    = 3'd4;
  localparam logic [2:0] AR   = 3'd5;
  localparam logic [2:0] R    = 3'd6;
  localparam logic [2:0] DONE = 3'd7;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [DATA_W-1:0] seed_q;
  logic              write_q;
  logic [7:0]        beat;

  logic [DATA_W-1:0] beat_data;
  logic [12:0]       span;
  logic [12:0]       end_off;
  logic              illegal;
  logic              last_beat;

  // Worst response is simply the numerically largest code seen.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  // Mismatch counter saturates at 256 (one more than the largest beat index).
  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'd256) ? v : v + 9'd1;
  endfunction

  assign beat_data = seed_q + {{(DATA_W-8){1'b0}}, beat};
  assign last_beat = (beat == len_q);
  // Burst must start 8-byte aligned and end at or before the 4KB page boundary.
  assign span      = ({5'd0, len_q} + 13'd1) << 3;
  assign end_off   = {1'b0, addr_q[11:0]} + span;
  assign illegal   = (addr_q[2:0] != 3'd0) || (end_off > 13'd4096);

  // Command latch, burst FSM and status accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      write_q     <= 1'b0;
      beat        <= '0;
      st_resp     <= '0;
      st_mismatch <= '0;
      st_illegal  <= 1'b0;
      st_proto    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q      <= cmd_addr;
          len_q       <= cmd_len;
          seed_q      <= cmd_seed;
          write_q     <= cmd_write;
          beat        <= '0;
          st_resp     <= '0;
          st_mismatch <= '0;
          st_illegal  <= 1'b0;
          st_proto    <= 1'b0;
          state       <= CHK;
        end
        CHK: begin
          if (illegal) begin
            st_illegal <= 1'b1;
            state      <= DONE;
          end else begin
            state <= write_q ? AW : AR;
          end
        end
        AW: if (awready) begin
          beat  <= '0;
          state <= W;
        end
        W: if (wready) begin
          if (last_beat) state <= B;
          else           beat  <= beat + 8'd1;
        end
        B: if (bvalid) begin
          st_resp <= resp_max(st_resp, bresp);
          state   <= DONE;
        end
        AR: if (arready) begin
          beat  <= '0;
          state <= R;
        end
        R: if (rvalid) begin
          st_resp <= resp_max(st_resp, rresp);
          if (rdata != beat_data) st_mismatch <= sat_inc(st_mismatch);
          if (rlast != last_beat) st_proto <= 1'b1;
          if (last_beat) state <= DONE;
          else           beat  <= beat + 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and handshake outputs decoded from state and latched command.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    awaddr    = addr_q;
    awlen     = len_q;
    awsize    = 3'd3;
    awburst   = 2'b01;
    awlock    = 1'b0;
    awcache   = CACHE_VAL;
    awprot    = 3'd0;
    awvalid   = (state == AW);
    wvalid    = (state == W);
    wdata     = wvalid ? beat_data : '0;
    wstrb     = wvalid ? '1 : '0;
    wlast     = wvalid && last_beat;
    bready    = (state == B);
    araddr    = addr_q;
    arlen     = len_q;
    arsize    = 3'd3;
    arburst   = 2'b01;
    arlock    = 1'b0;
    arcache   = CACHE_VAL;
    arprot    = 3'd0;
    arvalid   = (state == AR);
    rready    = (state == R);
  end

endmodule
